player_motion_ctrl: RTL and testbench

Per-frame kinematics and animation controller for one playable character. It sits directly upstream of the VGA address generator and produces the `img_x`/`img_y`/`frame_idx`/`is_moving`/`face_left` set that the generator latches on vsync. Each frame it applies walk, jump and gravity, resolves collisions against the tile map through a single-cycle probe port, and advances the idle/walk animation index. Two instances are used, one per character.

---
 rtl/player_motion_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_player_motion_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/player_motion_ctrl.sv
// Per-frame walk/jump/gravity update with tile-map collision probing and
// idle/walk animation indexing for one playable character.
module player_motion_ctrl #(
  parameter int START_X     = 32,
  parameter int START_Y     = 320,
  parameter int WALK_SPD    = 2,
  parameter int JUMP_V      = 8,
  parameter int MAX_FALL    = 6,
  parameter int ANIM_DIV    = 6,
  parameter int IDLE_FRAMES = 4,
  parameter int WALK_FRAMES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  output logic [4:0] probe_gx,
  output logic [3:0] probe_gy,
  input  logic       probe_solid,
  output logic [9:0] img_x,
  output logic [9:0] img_y,
  output logic [2:0] frame_idx,
  output logic       is_moving,
  output logic       face_left,
  output logic       on_ground,
  output logic       busy
);

  localparam int unsigned CW = 11;
  localparam int unsigned VW = 8;
  localparam int unsigned AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  typedef logic signed [CW-1:0] coord_t;
  typedef logic signed [VW-1:0] vel_t;
  typedef enum logic [2:0] {S_IDLE, S_HX0, S_HX1, S_VY0, S_VY1, S_COMMIT} state_t;

  localparam logic signed [1:0] DIR_R = 2'sb01;
  localparam logic signed [1:0] DIR_L = 2'sb11;
  localparam coord_t STEP     = coord_t'(WALK_SPD);
  localparam vel_t   JUMP_VEL = vel_t'(JUMP_V);
  localparam vel_t   FALL_VEL = vel_t'(MAX_FALL);

  // Leading-edge hitbox column for a horizontal move.
  function automatic coord_t hx_px(coord_t nx, logic signed [1:0] d);
    return (d == DIR_R) ? nx + coord_t'(28) : nx + coord_t'(3);
  endfunction

  // Hitbox row edge probed for the vertical step (or the floor check at rest).
  function automatic coord_t vy_px(coord_t y, coord_t ny, vel_t v);
    if (!v[VW-1] && (v != '0)) return ny + coord_t'(31);
    else if (v[VW-1])          return ny + coord_t'(5);
    else                       return y + coord_t'(32);
  endfunction

  state_t            state_q, state_d;
  logic signed [1:0] dir_q, dir_d;
  coord_t            nx_q, nx_d, xr_q, xr_d, ny_q, ny_d, row_q, row_d;
  vel_t              vyn_q, vyn_d, vy_q, vy_d;
  logic              hit_q, hit_d, skip_q, skip_d, oob_q, oob_d;
  logic [4:0]        gx_q, gx_d;
  logic [3:0]        gy_q, gy_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic              og_q, og_d, fl_q, fl_d, mv_q, mv_d, busy_q, busy_d;
  logic [2:0]        fi_q, fi_d;
  logic [AW-1:0]     cnt_q, cnt_d;

  coord_t            xs, ys, pa_x, pa_y, nx_n, xr_n, ny_n, y_res;
  logic              pa_en, pa_force, oob_c, mv_n, probe_hit_c;
  logic signed [1:0] dir_n;
  vel_t              vyn_n;
  logic [2:0]        fi_last;

  assign xs          = coord_t'({1'b0, x_q});
  assign ys          = coord_t'({1'b0, y_q});
  assign probe_hit_c = !skip_q && (oob_q || probe_solid);

  // State and datapath registers; reset aborts any update in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= '0;
      nx_q    <= '0;
      xr_q    <= '0;
      ny_q    <= '0;
      row_q   <= '0;
      vyn_q   <= '0;
      vy_q    <= '0;
      hit_q   <= 1'b0;
      skip_q  <= 1'b0;
      oob_q   <= 1'b0;
      gx_q    <= '0;
      gy_q    <= '0;
      x_q     <= 10'(START_X);
      y_q     <= 10'(START_Y);
      og_q    <= 1'b0;
      fl_q    <= 1'b0;
      mv_q    <= 1'b0;
      busy_q  <= 1'b0;
      fi_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      nx_q    <= nx_d;
      xr_q    <= xr_d;
      ny_q    <= ny_d;
      row_q   <= row_d;
      vyn_q   <= vyn_d;
      vy_q    <= vy_d;
      hit_q   <= hit_d;
      skip_q  <= skip_d;
      oob_q   <= oob_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      x_q     <= x_d;
      y_q     <= y_d;
      og_q    <= og_d;
      fl_q    <= fl_d;
      mv_q    <= mv_d;
      busy_q  <= busy_d;
      fi_q    <= fi_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, probe address for the upcoming state, and commit values.
  always_comb begin
    state_d = state_q;  dir_d = dir_q;  nx_d = nx_q;  xr_d = xr_q;
    ny_d = ny_q;  row_d = row_q;  vyn_d = vyn_q;  vy_d = vy_q;
    hit_d = hit_q;  skip_d = skip_q;  oob_d = 1'b0;  gx_d = '0;  gy_d = '0;
    x_d = x_q;  y_d = y_q;  og_d = og_q;  fl_d = fl_q;  mv_d = mv_q;
    fi_d = fi_q;  cnt_d = cnt_q;
    pa_en = 1'b0;  pa_x = '0;  pa_y = '0;  pa_force = 1'b0;  oob_c = 1'b0;
    dir_n = '0;  nx_n = '0;  vyn_n = '0;  xr_n = '0;  ny_n = '0;
    y_res = '0;  mv_n = 1'b0;  fi_last = '0;

    unique case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          if (btn_right && !btn_left)      dir_n = DIR_R;
          else if (btn_left && !btn_right) dir_n = DIR_L;
          nx_n = (dir_n == DIR_R) ? xs + STEP : (dir_n == DIR_L) ? xs - STEP : xs;
          if (btn_jump && og_q) vyn_n = -JUMP_VEL;
          else if (!og_q)       vyn_n = (vy_q >= FALL_VEL) ? FALL_VEL : vy_q + vel_t'(1);
          state_d  = S_HX0;
          dir_d    = dir_n;
          nx_d     = nx_n;
          vyn_d    = vyn_n;
          hit_d    = 1'b0;
          skip_d   = (dir_n == 2'sb00);
          pa_en    = 1'b1;
          pa_x     = hx_px(nx_n, dir_n);
          pa_y     = ys + coord_t'(5);
          pa_force = nx_n[CW-1];
        end
      end
      S_HX0: begin
        hit_d    = probe_hit_c;
        state_d  = S_HX1;
        pa_en    = 1'b1;
        pa_x     = hx_px(nx_q, dir_q);
        pa_y     = ys + coord_t'(31);
        pa_force = nx_q[CW-1];
      end
      S_HX1: begin
        xr_n    = (hit_q || probe_hit_c) ? xs : nx_q;
        ny_n    = ys + coord_t'(vyn_q);
        xr_d    = xr_n;
        ny_d    = ny_n;
        hit_d   = 1'b0;
        skip_d  = 1'b0;
        state_d = S_VY0;
        pa_en   = 1'b1;
        pa_x    = xr_n + coord_t'(3);
        pa_y    = vy_px(ys, ny_n, vyn_q);
        row_d   = pa_y >>> 5;
      end
      S_VY0: begin
        hit_d   = probe_hit_c;
        state_d = S_VY1;
        pa_en   = 1'b1;
        pa_x    = xr_q + coord_t'(28);
        pa_y    = vy_px(ys, ny_q, vyn_q);
      end
      S_VY1: begin
        hit_d   = hit_q || probe_hit_c;
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        x_d     = xr_q[9:0];
        y_res   = ny_q;
        vy_d    = vyn_q;
        og_d    = 1'b0;
        if (vyn_q == '0) begin
          vy_d = '0;
          og_d = hit_q;
        end else if (hit_q) begin
          vy_d = '0;
          if (!vyn_q[VW-1]) begin
            y_res = (row_q <<< 5) - coord_t'(32);
            og_d  = 1'b1;
          end else begin
            y_res = ((row_q + coord_t'(1)) <<< 5) - coord_t'(5);
          end
        end
        y_d = y_res[9:0];
        if (dir_q == DIR_L)      fl_d = 1'b1;
        else if (dir_q == DIR_R) fl_d = 1'b0;
        mv_n    = (dir_q != 2'sb00);
        mv_d    = mv_n;
        fi_last = mv_n ? 3'(WALK_FRAMES - 1) : 3'(IDLE_FRAMES - 1);
        if (mv_n != mv_q) begin
          cnt_d = '0;
          fi_d  = '0;
        end else if (cnt_q == AW'(ANIM_DIV - 1)) begin
          cnt_d = '0;
          fi_d  = (fi_q >= fi_last) ? 3'd0 : fi_q + 3'd1;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pa_en) begin
      oob_c = pa_force || pa_x[CW-1] || (pa_x[9:0] >= 10'd640) ||
              pa_y[CW-1] || (pa_y[9:0] >= 10'd480);
      oob_d = oob_c;
      if (!oob_c) begin
        gx_d = pa_x[9:5];
        gy_d = pa_y[8:5];
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  assign probe_gx  = gx_q;
  assign probe_gy  = gy_q;
  assign img_x     = x_q;
  assign img_y     = y_q;
  assign frame_idx = fi_q;
  assign is_moving = mv_q;
  assign face_left = fl_q;
  assign on_ground = og_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl with a small tile-map model.
module tb_player_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
  logic [4:0] probe_gx;
  logic [3:0] probe_gy;
  logic       probe_solid;
  logic [9:0] img_x, img_y;
  logic [2:0] frame_idx;
  logic       is_moving, face_left, on_ground, busy;
  logic       wall_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #20 clk = ~clk;

  // Floor on row 11; optional wall in column 5, rows 9-10.
  assign probe_solid = (probe_gy == 4'd11) ||
                       (wall_en && (probe_gx == 5'd5) && ((probe_gy == 4'd9) || (probe_gy == 4'd10)));

  player_motion_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .probe_gx(probe_gx), .probe_gy(probe_gy), .probe_solid(probe_solid),
    .img_x(img_x), .img_y(img_y), .frame_idx(frame_idx),
    .is_moving(is_moving), .face_left(face_left), .on_ground(on_ground), .busy(busy)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_btn(input logic l, input logic r, input logic j);
    btn_left = l; btn_right = r; btn_jump = j;
  endtask

  // One frame tick; returns how many sampled cycles busy stayed high.
  task automatic tick(output int bc);
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    bc = 0;
    while (busy && (bc < 20)) begin
      bc++;
      @(negedge clk);
    end
    chk("busy_fall", busy, 0);
  endtask

  int bc, xe, ymax;
  int jump_y[18] = '{312, 305, 299, 294, 290, 287, 285, 284, 284,
                     285, 287, 290, 294, 299, 305, 311, 317, 320};

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_x", img_x, 32);
    chk("rst_y", img_y, 320);
    chk("rst_fi", frame_idx, 0);
    chk("rst_mv", is_moving, 0);
    chk("rst_fl", face_left, 0);
    chk("rst_og", on_ground, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gx", probe_gx, 0);
    chk("rst_gy", probe_gy, 0);
    rst = 1'b0;
    @(negedge clk);

    // First tick: falls one pixel onto the floor and snaps to y=320.
    set_btn(0, 0, 0);
    tick(bc);
    chk("busy_len", bc, 5);
    chk("land_y", img_y, 320);
    chk("land_og", on_ground, 1);
    chk("land_x", img_x, 32);

    // Jump arc and landing.
    ymax = 0;
    for (int i = 0; i < 18; i++) begin
      set_btn(0, 0, (i == 0));
      tick(bc);
      if (img_y > ymax) ymax = img_y;
      chk($sformatf("jump_y%0d", i), img_y, jump_y[i]);
      chk($sformatf("jump_og%0d", i), on_ground, (i == 17) ? 1 : 0);
    end
    chk("jump_ymax", ymax, 320);

    // Walk right, animation stepping every 6 commits over 6 frames.
    set_btn(0, 1, 0);
    for (int k = 0; k < 37; k++) begin
      tick(bc);
      chk($sformatf("walk_x%0d", k), img_x, 32 + 2 * (k + 1));
      chk($sformatf("walk_fi%0d", k), frame_idx, (k / 6) % 6);
    end
    chk("walk_mv", is_moving, 1);
    chk("walk_fl", face_left, 0);
    set_btn(0, 0, 0);
    tick(bc);
    chk("stop_mv", is_moving, 0);
    chk("stop_fi", frame_idx, 0);
    chk("stop_x", img_x, 106);

    // Wall at column 5 stops the sprite at x=130.
    wall_en = 1'b1;
    set_btn(0, 1, 0);
    xe = 106;
    for (int k = 0; k < 15; k++) begin
      xe = (xe + 2 > 130) ? 130 : xe + 2;
      tick(bc);
      chk($sformatf("wall_x%0d", k), img_x, xe);
    end
    chk("wall_mv", is_moving, 1);
    chk("wall_fl", face_left, 0);

    // Walk left into the screen edge.
    set_btn(1, 0, 0);
    for (int k = 0; k < 67; k++) begin
      xe = (xe >= 2) ? xe - 2 : 0;
      tick(bc);
      chk($sformatf("left_x%0d", k), img_x, xe);
    end
    chk("edge_fl", face_left, 1);
    chk("edge_mv", is_moving, 1);
    chk("edge_y", img_y, 320);

    // Both buttons: no motion, facing retained.
    set_btn(1, 1, 0);
    tick(bc);
    chk("both_x", img_x, 0);
    chk("both_mv", is_moving, 0);
    chk("both_fl", face_left, 1);

    // Second tick while busy is dropped.
    set_btn(0, 1, 0);
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    repeat (12) @(negedge clk);
    chk("dbl_x", img_x, 2);
    chk("dbl_busy", busy, 0);
    chk("dbl_fl", face_left, 0);

    // Reset in the middle of the vertical probes.
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_x", img_x, 32);
    chk("mid_rst_y", img_y, 320);
    chk("mid_rst_fi", frame_idx, 0);
    chk("mid_rst_mv", is_moving, 0);
    chk("mid_rst_fl", face_left, 0);
    chk("mid_rst_og", on_ground, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_gx", probe_gx, 0);
    chk("mid_rst_gy", probe_gy, 0);
    @(negedge clk); rst = 1'b0;
    set_btn(0, 0, 0);
    repeat (8) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_x", img_x, 32);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
